// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
//   state_e : access sequencer states (idle, timed access, ack).
//   sel_e   : which requester owns the current access.
//   Strobe/drive reset constants for the SRAM pins.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StAck    = 2'd2
    } state_e;

    typedef enum logic {
        SelP0 = 1'b0,
        SelP1 = 1'b1
    } sel_e;

    // Active-low strobes park deasserted; DQ is released.
    localparam logic StrobeRst = 1'b1;
    localparam logic DqOeRst   = 1'b0;

endpackage

// File: rtl/sram_arb_prio.sv
// sram_arb_prio: grant selection for the two SRAM requesters.
// Port 0 wins by default; port 1 is forced once it has watched MAX_WAIT
// consecutive port-0 grants (MAX_WAIT = 0 gives pure fixed priority).
// Ports:
//   clk, reset    clock, async active-high reset
//   arb_en_i      sequencer is idle and may grant this cycle
//   p0_req_i      port 0 request
//   p1_req_i      port 1 request
//   grant_o       a grant is issued this cycle
//   sel_o         granted port (valid with grant_o)
module sram_arb_prio
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en_i,
    input  logic p0_req_i,
    input  logic p1_req_i,
    output logic grant_o,
    output sel_e sel_o
);

    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic [WaitW-1:0] wait_q, wait_d;
    logic             force_p1;

    assign force_p1 = (MAX_WAIT > 0) && p1_req_i && (wait_q == WaitMax);

    always_comb begin
        grant_o = arb_en_i && (p0_req_i || p1_req_i);
        sel_o   = (force_p1 || !p0_req_i) ? SelP1 : SelP0;
        wait_d  = wait_q;
        // The counter only moves while the sequencer is arbitrating.
        if (arb_en_i) begin
            if (!p1_req_i || sel_o == SelP1) begin
                wait_d = '0;
            end else if (wait_q != WaitMax) begin
                wait_d = wait_q + WaitW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and fixed-timing access sequencer for a
// 16-bit asynchronous SRAM. Port 0 (audio) has priority with a starvation
// guard for port 1 (bridge). All SRAM-facing outputs are registered; the
// tristate DQ buffer lives in the parent.
// Optional: define SRAM_ARB_STATS_EN to add p0_grants/p1_grants (32-bit,
// wrapping, +1 per ack) and max_p1_wait (8-bit, saturating, longest
// p1_req-rise-to-p1_ack in cycles).
// Ports:
//   clk, reset                        clock, async active-high reset
//   pN_req/we/addr/wdata/be           request + command, held until ack
//   pN_ack                            one-cycle completion pulse
//   pN_rdata                          read data, held until next read
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in   SRAM address/data
//   sram_ce_n/oe_n/we_n/lb_n/ub_n     active-low SRAM strobes
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,  // two byte lanes only
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_WAIT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       p0_grants,
    output logic [31:0]       p1_grants,
    output logic [7:0]        max_p1_wait
`endif
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    sel_e              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic              grant;
    sel_e              grant_sel;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [1:0]        g_be;

    sram_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .arb_en_i (state_q == StIdle),
        .p0_req_i (p0_req),
        .p1_req_i (p1_req),
        .grant_o  (grant),
        .sel_o    (grant_sel)
    );

    // Command of the port being granted this cycle.
    assign g_we    = (grant_sel == SelP1) ? p1_we    : p0_we;
    assign g_addr  = (grant_sel == SelP1) ? p1_addr  : p0_addr;
    assign g_wdata = (grant_sel == SelP1) ? p1_wdata : p0_wdata;
    assign g_be    = (grant_sel == SelP1) ? p1_be    : p0_be;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        lb_n_d     = lb_n_q;
        ub_n_d     = ub_n_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        case (state_q)
            StIdle: begin
                dq_oe_d = 1'b0;
                if (grant) begin
                    sel_d    = grant_sel;
                    we_d     = g_we;
                    addr_d   = g_addr;
                    dq_out_d = g_wdata;
                    ce_n_d   = 1'b0;
                    lb_n_d   = ~g_be[0];
                    ub_n_d   = ~g_be[1];
                    we_n_d   = ~g_we;
                    oe_n_d   = g_we;
                    dq_oe_d  = g_we;
                    cnt_d    = WaitLoad;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (sel_q == SelP1) begin
                            p1_rdata_d = sram_dq_in;
                        end else begin
                            p0_rdata_d = sram_dq_in;
                        end
                    end
                    p0_ack_d = (sel_q == SelP0);
                    p1_ack_d = (sel_q == SelP1);
                    ce_n_d   = StrobeRst;
                    oe_n_d   = StrobeRst;
                    we_n_d   = StrobeRst;
                    lb_n_d   = StrobeRst;
                    ub_n_d   = StrobeRst;
                    // Writes keep driving DQ one cycle past WE_N rising (hold time).
                    dq_oe_d  = we_q;
                    state_d  = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                dq_oe_d = DqOeRst;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= SelP0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= DqOeRst;
            ce_n_q     <= StrobeRst;
            oe_n_q     <= StrobeRst;
            we_n_q     <= StrobeRst;
            lb_n_q     <= StrobeRst;
            ub_n_q     <= StrobeRst;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] p0_grants_q, p1_grants_q;
    logic [7:0]  max_wait_q, p1_wait_cnt_q;
    logic        p1_pend_q;

    // A wait starts on any cycle port 1 requests with nothing pending and no
    // ack showing, so a req held through its ack counts as a fresh request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_grants_q   <= '0;
            p1_grants_q   <= '0;
            max_wait_q    <= '0;
            p1_wait_cnt_q <= '0;
            p1_pend_q     <= 1'b0;
        end else begin
            if (p0_ack_q) begin
                p0_grants_q <= p0_grants_q + 32'd1;
            end
            if (p1_ack_q) begin
                p1_grants_q <= p1_grants_q + 32'd1;
            end
            if (p1_pend_q) begin
                if (p1_ack_q) begin
                    p1_pend_q <= 1'b0;
                    if (p1_wait_cnt_q > max_wait_q) begin
                        max_wait_q <= p1_wait_cnt_q;
                    end
                end else if (p1_wait_cnt_q != 8'hFF) begin
                    p1_wait_cnt_q <= p1_wait_cnt_q + 8'd1;
                end
            end else if (p1_req && !p1_ack_q) begin
                p1_pend_q     <= 1'b1;
                p1_wait_cnt_q <= 8'd1;
            end
        end
    end

    assign p0_grants   = p0_grants_q;
    assign p1_grants   = p1_grants_q;
    assign max_p1_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [19:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic [1:0]  p0_be = '0, p1_be = '0;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] p0_grants, p1_grants;
    logic [7:0]  max_p1_wait;
`endif

    // Second instance with the starvation guard disabled.
    logic        n0_req = 1'b0, n1_req = 1'b0;
    logic        n0_ack, n1_ack;
    logic [15:0] n0_rdata, n1_rdata, n_dq_out;
    logic [19:0] n_addr;
    logic        n_dq_oe, n_ce_n, n_oe_n, n_we_n, n_lb_n, n_ub_n;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] n0_grants, n1_grants;
    logic [7:0]  n_max_wait;
`endif

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1), .MAX_WAIT(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_be(p0_be), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be(p1_be), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
`ifdef SRAM_ARB_STATS_EN
        , .p0_grants(p0_grants), .p1_grants(p1_grants), .max_p1_wait(max_p1_wait)
`endif
    );

    sram_arbiter #(
        .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1), .MAX_WAIT(0)
    ) u_dut_nw (
        .clk(clk), .reset(reset),
        .p0_req(n0_req), .p0_we(1'b0), .p0_addr(20'h00010), .p0_wdata(16'h0000),
        .p0_be(2'b11), .p0_ack(n0_ack), .p0_rdata(n0_rdata),
        .p1_req(n1_req), .p1_we(1'b0), .p1_addr(20'h00020), .p1_wdata(16'h0000),
        .p1_be(2'b11), .p1_ack(n1_ack), .p1_rdata(n1_rdata),
        .sram_addr(n_addr), .sram_dq_out(n_dq_out), .sram_dq_oe(n_dq_oe),
        .sram_dq_in(16'h0000), .sram_ce_n(n_ce_n), .sram_oe_n(n_oe_n),
        .sram_we_n(n_we_n), .sram_lb_n(n_lb_n), .sram_ub_n(n_ub_n)
`ifdef SRAM_ARB_STATS_EN
        , .p0_grants(n0_grants), .p1_grants(n1_grants), .max_p1_wait(n_max_wait)
`endif
    );

    // Asynchronous SRAM model: combinational read, byte-lane write per clock.
    logic [15:0] mem [256];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    // Issues one transfer from IDLE and returns to IDLE. lat counts edges from
    // the request until ack is seen (-1 on timeout).
    task automatic do_xfer(input bit port, input logic we, input logic [19:0] addr,
                           input logic [15:0] wd, input logic [1:0] be,
                           output int lat, output logic [15:0] rd,
                           output logic [4:0] acc_strb, output logic [5:0] ack_strb,
                           output logic post_oe);
        @(negedge clk);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be; p0_req = 1'b1;
        end
        lat = -1; rd = '0; acc_strb = '1; ack_strb = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) acc_strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n};
            if ((port && p1_ack) || (!port && p0_ack)) begin
                lat = i;
                rd = port ? p1_rdata : p0_rdata;
                ack_strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe};
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk); #1;
        post_oe = sram_dq_oe;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 11111",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        checks++;
        if ({sram_dq_oe, p0_ack, p1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_oe_acks: got %b expected 000", {sram_dq_oe, p0_ack, p1_ack});
        end
        checks++;
        if (sram_addr !== 20'h0 || sram_dq_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h/%h expected 00000/0000", sram_addr, sram_dq_out);
        end
        checks++;
        if (p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0000/0000", p0_rdata, p1_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sram_ce_n, sram_dq_oe, p0_ack, p1_ack} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 1000",
                     {sram_ce_n, sram_dq_oe, p0_ack, p1_ack});
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic [4:0] acc; logic [5:0] ack; logic poe;
        do_xfer(1'b1, 1'b1, 20'h00010, 16'hBEEF, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++;
        if (acc !== 5'b01000) begin errors++; $display("FAIL wr_access_strobes: got %b expected 01000", acc); end
        checks++;
        if (ack !== 6'b111111) begin errors++; $display("FAIL wr_ack_strobes_oe: got %b expected 111111", ack); end
        checks++;
        if (poe !== 1'b0) begin errors++; $display("FAIL wr_idle_oe: got %b expected 0", poe); end
        do_xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected beef", rd); end
        checks++;
        if (acc !== 5'b00100) begin errors++; $display("FAIL rd_access_strobes: got %b expected 00100", acc); end
        checks++;
        if (ack !== 6'b111110) begin errors++; $display("FAIL rd_ack_strobes_oe: got %b expected 111110", ack); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (p1_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data_held: got %h expected beef", p1_rdata); end
    endtask

    task automatic test_byte_lane();
        int lat; logic [15:0] rd; logic [4:0] acc; logic [5:0] ack; logic poe;
        do_xfer(1'b1, 1'b1, 20'h00010, 16'h0012, 2'b01, lat, rd, acc, ack, poe);
        checks++;
        if (acc !== 5'b01001) begin errors++; $display("FAIL lane_lo_strobes: got %b expected 01001", acc); end
        do_xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (rd !== 16'hBE12) begin errors++; $display("FAIL lane_lo_readback: got %h expected be12", rd); end
        // No lanes enabled: still a full timed, acked cycle that changes nothing.
        do_xfer(1'b0, 1'b1, 20'h00010, 16'hFFFF, 2'b00, lat, rd, acc, ack, poe);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL be00_latency: got %0d expected 3", lat); end
        checks++;
        if (acc !== 5'b01011) begin errors++; $display("FAIL be00_strobes: got %b expected 01011", acc); end
        do_xfer(1'b0, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (rd !== 16'hBE12) begin errors++; $display("FAIL be00_readback: got %h expected be12", rd); end
    endtask

    task automatic test_simultaneous();
        int t0 = -1; int t1 = -1; int overlap = 0;
        @(negedge clk);
        p0_we = 1'b0; p0_addr = 20'h00010; p0_be = 2'b11; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 20'h00010; p1_be = 2'b11; p1_req = 1'b1;
        for (int i = 1; i <= 30 && (t0 < 0 || t1 < 0); i++) begin
            @(posedge clk); #1;
            if (p0_ack && p1_ack) overlap++;
            if (p0_ack) begin t0 = i; p0_req = 1'b0; end
            if (p1_ack) begin t1 = i; p1_req = 1'b0; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (t0 !== 3) begin errors++; $display("FAIL sim_p0_ack_cycle: got %0d expected 3", t0); end
        checks++;
        if (t1 !== 7) begin errors++; $display("FAIL sim_p1_ack_cycle: got %0d expected 7", t1); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL sim_ack_overlap: got %0d expected 0", overlap); end
        checks++;
        if (p0_rdata !== 16'hBE12 || p1_rdata !== 16'hBE12) begin
            errors++;
            $display("FAIL sim_rdata: got %h/%h expected be12/be12", p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_starvation();
        int n = 0; logic [5:0] order = '0;
        @(negedge clk);
        p0_we = 1'b0; p0_addr = 20'h00010; p0_be = 2'b11; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 20'h00010; p1_be = 2'b11; p1_req = 1'b1;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(posedge clk); #1;
            if (p0_ack && n < 6) begin order[5-n] = 1'b0; n++; end
            if (p1_ack && n < 6) begin order[5-n] = 1'b1; n++; p1_req = 1'b0; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n !== 6 || order !== 6'b000010) begin
            errors++;
            $display("FAIL starve_grant_order: got n=%0d %b expected n=6 000010", n, order);
        end
    endtask

    task automatic test_no_guard();
        int a0 = 0; int a1 = 0;
        @(negedge clk);
        n0_req = 1'b1; n1_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (n0_ack) a0++;
            if (n1_ack) a1++;
        end
        n0_req = 1'b0; n1_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (a1 !== 0) begin errors++; $display("FAIL noguard_p1_grants: got %0d expected 0", a1); end
        checks++;
        if (a0 !== 10) begin errors++; $display("FAIL noguard_p0_grants: got %0d expected 10", a0); end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0; int lat; logic [15:0] rd; logic [4:0] acc; logic [5:0] ack; logic poe;
        @(negedge clk);
        p1_we = 1'b1; p1_addr = 20'h00030; p1_wdata = 16'h1234; p1_be = 2'b11; p1_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midwr_in_access: got we_n=%b expected 0", sram_we_n); end
        reset = 1'b1;
        p1_req = 1'b0;
        #1;
        checks++;
        if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b110) begin
            errors++;
            $display("FAIL midwr_async_reset: got %b expected 110", {sram_we_n, sram_ce_n, sram_dq_oe});
        end
        checks++;
        if (p1_rdata !== 16'h0000) begin errors++; $display("FAIL midwr_rdata_clear: got %h expected 0000", p1_rdata); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL midwr_no_ack: got %0d expected 0", acks); end
        do_xfer(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (lat !== 3 || rd !== 16'hBE12) begin
            errors++;
            $display("FAIL midwr_recover: got lat=%0d data=%h expected lat=3 data=be12", lat, rd);
        end
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats();
        int lat; logic [15:0] rd; logic [4:0] acc; logic [5:0] ack; logic poe;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        checks++;
        if (p0_grants !== 32'd0 || p1_grants !== 32'd0 || max_p1_wait !== 8'd0) begin
            errors++;
            $display("FAIL stats_start: got %0d/%0d/%0d expected 0/0/0", p0_grants, p1_grants, max_p1_wait);
        end
        for (int i = 0; i < 5; i++) do_xfer(1'b0, 1'b0, 20'h00010, 16'h0, 2'b11, lat, rd, acc, ack, poe);
        for (int i = 0; i < 3; i++) do_xfer(1'b1, 1'b0, 20'h00010, 16'h0, 2'b11, lat, rd, acc, ack, poe);
        checks++;
        if (p0_grants !== 32'd5 || p1_grants !== 32'd3) begin
            errors++;
            $display("FAIL stats_grants: got %0d/%0d expected 5/3", p0_grants, p1_grants);
        end
        checks++;
        if (max_p1_wait !== 8'd3) begin errors++; $display("FAIL stats_max_wait: got %0d expected 3", max_p1_wait); end
        @(negedge clk); reset = 1'b1;
        #1;
        checks++;
        if (p0_grants !== 32'd0 || p1_grants !== 32'd0 || max_p1_wait !== 8'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", p0_grants, p1_grants, max_p1_wait);
        end
        @(negedge clk); reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_simultaneous();
        test_starvation();
        test_no_guard();
        test_reset_mid_write();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
